cla_subtractor_pipe: RTL

//   Pipelined two's-complement subtractor: io_diff = io_a - io_b - io_borrow_in.

---
 rtl/cla_subtractor_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cla_subtractor_pipe.sv
// cla_subtractor_pipe: two-stage pipelined subtractor computing a - b - borrow_in
// as a + ~b + cin using GROUP-bit lookahead groups and a second-level lookahead
// across groups. Valid/ready handshake on both the input and the output side.
module cla_subtractor_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_borrow_in,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_diff,
  output logic             io_borrow,
  output logic             io_overflow,
  output logic             io_zero
);

  localparam int NG = WIDTH / GROUP;

  // Stage 1 registers: operands, inverted subtrahend and per-bit p/g/x
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_nb_q;
  logic             s1_cin_q;
  logic [WIDTH-1:0] s1_p_q;
  logic [WIDTH-1:0] s1_g_q;
  logic [WIDTH-1:0] s1_x_q;

  // Stage 2 registers: result and flags
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_diff_q;
  logic             s2_borrow_q;
  logic             s2_overflow_q;
  logic             s2_zero_q;

  // Handshake control
  logic s2_load_ok;
  logic s1_adv;
  logic in_fire;

  // Stage 2 combinational datapath
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d;
  logic             overflow_d;
  logic             zero_d;
  logic             acc;
  logic             prod;

  // Next-state values for the stage valid bits
  logic s1_valid_d;
  logic s2_valid_d;

  // Advance rules: stage 2 may load when empty or draining; the input side
  // sees ready whenever stage 1 is empty or is moving forward this cycle.
  always_comb begin
    s2_load_ok  = !s2_valid_q || io_out_ready;
    s1_adv      = s1_valid_q && s2_load_ok;
    io_in_ready = !s1_valid_q || s1_adv;
    in_fire     = io_in_valid && io_in_ready;
    s1_valid_d  = in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    s2_valid_d  = s1_adv ? 1'b1 : (io_out_ready ? 1'b0 : s2_valid_q);
  end

  // Group generate/propagate, lookahead carries and result flags from stage 1
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    bit_c = '0;
    acc   = 1'b0;
    prod  = 1'b1;

    for (int k = 0; k < NG; k++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = GROUP - 1; j >= 0; j--) begin
        acc  = acc | (prod & s1_g_q[k*GROUP + j]);
        prod = prod & s1_p_q[k*GROUP + j];
      end
      grp_g[k] = acc;
      grp_p[k] = prod;
    end

    grp_c[0] = s1_cin_q;
    for (int k = 0; k < NG; k++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int m = k; m >= 0; m--) begin
        acc  = acc | (prod & grp_g[m]);
        prod = prod & grp_p[m];
      end
      grp_c[k+1] = acc | (prod & s1_cin_q);
    end

    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        acc  = 1'b0;
        prod = 1'b1;
        for (int m = j - 1; m >= 0; m--) begin
          acc  = acc | (prod & s1_g_q[k*GROUP + m]);
          prod = prod & s1_p_q[k*GROUP + m];
        end
        bit_c[k*GROUP + j] = acc | (prod & grp_c[k]);
      end
    end

    diff_d     = s1_x_q ^ bit_c;
    borrow_d   = ~grp_c[NG];
    overflow_d = (s1_a_q[WIDTH-1] == s1_nb_q[WIDTH-1]) &&
                 (diff_d[WIDTH-1] != s1_a_q[WIDTH-1]);
    zero_d     = (diff_d == '0);
  end

  // Stage 1: capture operands and per-bit terms on an input transfer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_nb_q    <= '0;
      s1_cin_q   <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_x_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_a_q   <= io_a;
        s1_nb_q  <= ~io_b;
        s1_cin_q <= ~io_borrow_in;
        s1_p_q   <= io_a | ~io_b;
        s1_g_q   <= io_a & ~io_b;
        s1_x_q   <= io_a ^ ~io_b;
      end
    end
  end

  // Stage 2: register result and flags when stage 1 advances; hold on stall
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid_q    <= 1'b0;
      s2_diff_q     <= '0;
      s2_borrow_q   <= 1'b0;
      s2_overflow_q <= 1'b0;
      s2_zero_q     <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv) begin
        s2_diff_q     <= diff_d;
        s2_borrow_q   <= borrow_d;
        s2_overflow_q <= overflow_d;
        s2_zero_q     <= zero_d;
      end
    end
  end

  assign io_out_valid = s2_valid_q;
  assign io_diff      = s2_diff_q;
  assign io_borrow    = s2_borrow_q;
  assign io_overflow  = s2_overflow_q;
  assign io_zero      = s2_zero_q;

endmodule
